// File: rtl/vga_pkg.sv
// Types, default tile-grid dimensions and the tile address map shared
// by the tile painter and the display scan path.
package vga_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_WRITE,
        ST_DONE
    } state_t;

    localparam int TILE_ROWS_DEF = 8;
    localparam int TILE_COLS_DEF = 8;

    // One 32-bit word per tile, tiles packed row-major with 8 columns per row.
    function automatic logic [31:0] tile_addr(input logic [2:0] row, input logic [2:0] col);
        return {24'd0, row, col, 2'b00};
    endfunction

endpackage

// File: rtl/tile_cursor.sv
// Raster cursor over an inclusive tile rectangle: steps the column and
// wraps to the next row at the right edge.
module tile_cursor
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       advance,
    input  logic [2:0] row0,
    input  logic [2:0] row1,
    input  logic [2:0] col0,
    input  logic [2:0] col1,
    output logic [2:0] row,
    output logic [2:0] col,
    output logic       wrap,
    output logic       last
);

    assign wrap = (col == col1);
    assign last = wrap && (row == row1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            row <= '0;
            col <= '0;
        end else if (load) begin
            row <= row0;
            col <= col0;
        end else if (advance) begin
            if (wrap) begin
                col <= col0;
                row <= row + 3'd1;
            end else begin
                col <= col + 3'd1;
            end
        end
    end

endmodule

// File: rtl/tile_painter.sv
// Fills a rectangle of tiles with one colour by issuing one memory write
// per tile in raster order, honouring mem_ready back-pressure.
//
// state    | meaning
// ST_IDLE  | waiting for start; command inputs latched on start
// ST_CHECK | validate latched rectangle; reject with err or load cursor
// ST_WRITE | we held high; cursor advances on each accepted write
// ST_DONE  | one-cycle done pulse, then back to IDLE
module tile_painter
    import vga_pkg::*;
#(
    parameter int TILE_ROWS = TILE_ROWS_DEF,
    parameter int TILE_COLS = TILE_COLS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  row0,
    input  logic [2:0]  row1,
    input  logic [2:0]  col0,
    input  logic [2:0]  col1,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    input  logic        mem_ready,
    output logic        we,
    output logic [31:0] dir,
    output logic [31:0] dataout,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_t     state;
    logic [2:0] row0_q, row1_q, col0_q, col1_q;
    logic [7:0] r_q, g_q, b_q;
    logic [2:0] cur_row, cur_col;
    logic       cur_wrap, cur_last;
    logic       cmd_bad, accept, load;

    assign cmd_bad = (row0_q > row1_q) || (col0_q > col1_q) ||
                     (int'(row0_q) >= TILE_ROWS) || (int'(row1_q) >= TILE_ROWS) ||
                     (int'(col0_q) >= TILE_COLS) || (int'(col1_q) >= TILE_COLS);
    assign accept  = (state == ST_WRITE) && we && mem_ready;
    assign load    = (state == ST_CHECK) && !cmd_bad;

    tile_cursor u_cursor (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .advance (accept && !cur_last),
        .row0    (row0_q),
        .row1    (row1_q),
        .col0    (col0_q),
        .col1    (col1_q),
        .row     (cur_row),
        .col     (cur_col),
        .wrap    (cur_wrap),
        .last    (cur_last)
    );

    // Address and data come straight from registers, so they stay put while stalled.
    assign dir     = tile_addr(cur_row, cur_col);
    assign dataout = {r_q, 8'd0, g_q, b_q};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= ST_IDLE;
            we     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            row0_q <= '0;
            row1_q <= '0;
            col0_q <= '0;
            col1_q <= '0;
            r_q    <= '0;
            g_q    <= '0;
            b_q    <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        row0_q <= row0;
                        row1_q <= row1;
                        col0_q <= col0;
                        col1_q <= col1;
                        r_q    <= r;
                        g_q    <= g;
                        b_q    <= b;
                        busy   <= 1'b1;
                        state  <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (cmd_bad) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        we    <= 1'b1;
                        state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (accept && cur_last) begin
                        we    <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_painter.sv
// Drives directed and random fill commands into tile_painter and checks
// every write against a rectangle-walk model built from plain loops.
module tb_tile_painter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        mem_ready = 1'b0;
    logic [2:0]  row0 = '0, row1 = '0, col0 = '0, col1 = '0;
    logic [7:0]  r = '0, g = '0, b = '0;
    logic        we, busy, done, err;
    logic [31:0] dir, dataout;

    int total = 0;
    int bad   = 0;

    tile_painter dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .row0      (row0),
        .row1      (row1),
        .col0      (col0),
        .col1      (col1),
        .r         (r),
        .g         (g),
        .b         (b),
        .mem_ready (mem_ready),
        .we        (we),
        .dir       (dir),
        .dataout   (dataout),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic scramble();
        row0 = 3'($urandom_range(7));
        row1 = 3'($urandom_range(7));
        col0 = 3'($urandom_range(7));
        col1 = 3'($urandom_range(7));
        r    = 8'($urandom_range(255));
        g    = 8'($urandom_range(255));
        b    = 8'($urandom_range(255));
    endtask

    // mode: 0 ready always, 1 ready pattern 1,0,0 repeating, 2 random ready.
    // inject: pulse start mid-write and again during DONE.
    // rst_after: assert reset once this many writes were accepted (0 = never).
    task automatic run_cmd(input int r0, input int r1, input int c0, input int c1,
                           input int rr, input int gg, input int bb,
                           input int mode, input bit inject, input int rst_after);
        logic [31:0] q_dir[$];
        logic [31:0] q_dat[$];
        bit          finished;
        bit          mr;
        int          accepted;
        finished = 0;
        accepted = 0;
        if (r0 <= r1 && c0 <= c1) begin
            for (int i = r0; i <= r1; i++) begin
                for (int j = c0; j <= c1; j++) begin
                    q_dir.push_back(32'(i * 32 + j * 4));
                    q_dat.push_back((32'(rr) << 24) | (32'(gg) << 8) | 32'(bb));
                end
            end
        end

        @(negedge clk);
        start = 1'b1;
        row0 = 3'(r0); row1 = 3'(r1); col0 = 3'(c0); col1 = 3'(c1);
        r = 8'(rr); g = 8'(gg); b = 8'(bb);
        mem_ready = 1'($urandom_range(1));

        @(negedge clk);
        chk("accept_busy", 32'(busy), 32'd1);
        chk("check_we", 32'(we), 32'd0);
        start = 1'b0;
        scramble();

        if (q_dir.size() == 0) begin
            @(negedge clk);
            chk("err_pulse", 32'(err), 32'd1);
            chk("err_we", 32'(we), 32'd0);
            chk("err_busy", 32'(busy), 32'd0);
            @(negedge clk);
            chk("err_clear", 32'(err), 32'd0);
            chk("err_idle_we", 32'(we), 32'd0);
            return;
        end

        for (int cyc = 0; cyc < 500 && !finished; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (q_dir.size() == 0) begin
                chk("done", 32'(done), 32'd1);
                chk("done_we", 32'(we), 32'd0);
                chk("done_busy", 32'(busy), 32'd0);
                chk("done_err", 32'(err), 32'd0);
                start = inject;
                finished = 1;
            end else begin
                chk("we", 32'(we), 32'd1);
                chk("busy", 32'(busy), 32'd1);
                chk("done_early", 32'(done), 32'd0);
                chk("dir", dir, q_dir[0]);
                chk("data", dataout, q_dat[0]);
                if (rst_after > 0 && accepted == rst_after) begin
                    rst = 1'b0;
                    mem_ready = 1'($urandom_range(1));
                    @(negedge clk);
                    chk("rst_we", 32'(we), 32'd0);
                    chk("rst_busy", 32'(busy), 32'd0);
                    chk("rst_done", 32'(done), 32'd0);
                    chk("rst_dir", dir, 32'd0);
                    chk("rst_data", dataout, 32'd0);
                    rst = 1'b1;
                    repeat (3) begin
                        @(negedge clk);
                        chk("rst_no_done", 32'(done), 32'd0);
                        chk("rst_no_we", 32'(we), 32'd0);
                        chk("rst_idle_busy", 32'(busy), 32'd0);
                    end
                    return;
                end
                case (mode)
                    0:       mr = 1'b1;
                    1:       mr = (cyc % 3 == 0);
                    default: mr = 1'($urandom_range(1));
                endcase
                mem_ready = mr;
                scramble();
                if (inject && cyc == 1) begin
                    start = 1'b1;
                    r = ~8'(rr);
                    g = ~8'(gg);
                end
                if (mr) begin
                    void'(q_dir.pop_front());
                    void'(q_dat.pop_front());
                    accepted++;
                end
            end
        end

        if (!finished) begin
            chk("timeout", 32'd0, 32'd1);
        end else begin
            @(negedge clk);
            start = 1'b0;
            chk("post_done", 32'(done), 32'd0);
            chk("post_busy", 32'(busy), 32'd0);
            chk("post_we", 32'(we), 32'd0);
        end
    endtask

    initial begin
        int a0, a1, a2, a3, t;
        repeat (2) @(negedge clk);
        chk("reset_we", 32'(we), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_dir", dir, 32'd0);
        chk("reset_data", dataout, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        run_cmd(0, 0, 0, 0, 8'hFF, 8'h00, 8'h00, 0, 1'b0, 0);
        run_cmd(1, 2, 3, 4, 8'h12, 8'h34, 8'h56, 0, 1'b0, 0);
        run_cmd(1, 2, 3, 4, 8'hA5, 8'h5A, 8'hC3, 1, 1'b0, 0);
        run_cmd(3, 2, 0, 1, 8'h11, 8'h22, 8'h33, 0, 1'b0, 0);
        run_cmd(0, 1, 4, 2, 8'h11, 8'h22, 8'h33, 0, 1'b0, 0);
        run_cmd(2, 3, 1, 3, 8'h80, 8'h40, 8'h20, 2, 1'b1, 0);
        run_cmd(0, 1, 0, 2, 8'h01, 8'h02, 8'h03, 0, 1'b0, 2);
        run_cmd(5, 7, 6, 7, 8'hDE, 8'hAD, 8'hBE, 0, 1'b0, 0);
        run_cmd(7, 7, 7, 7, 8'h7F, 8'hFF, 8'h01, 1, 1'b1, 0);

        for (int k = 0; k < 25; k++) begin
            a0 = $urandom_range(7);
            a1 = $urandom_range(7);
            a2 = $urandom_range(7);
            a3 = $urandom_range(7);
            if ($urandom_range(3) != 0) begin
                if (a0 > a1) begin t = a0; a0 = a1; a1 = t; end
                if (a2 > a3) begin t = a2; a2 = a3; a3 = t; end
            end
            run_cmd(a0, a1, a2, a3, $urandom_range(255), $urandom_range(255),
                    $urandom_range(255), $urandom_range(2), 1'($urandom_range(1)),
                    ($urandom_range(4) == 0) ? 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
